// File: rtl/uart_led_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_led_cmd_pkg
// Shared definitions for the UART LED command parser:
//   - parser state encoding (legacy-compatible 3-bit localparams)
//   - ASCII constants for command letters, line terminators and responses
//   - 2-bit channel-select encoding and a channel-letter decode helper
// -----------------------------------------------------------------------------
package uart_led_cmd_pkg;

   // Parser states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_HI        = 3'd1;
   localparam state_t ST_LO        = 3'd2;
   localparam state_t ST_TERM      = 3'd3;
   localparam state_t ST_RESP_WAIT = 3'd4;
   localparam state_t ST_RESP_HOLD = 3'd5;

   // ASCII constants
   localparam logic [7:0] CH_R_UC = 8'h52;  // 'R'
   localparam logic [7:0] CH_R_LC = 8'h72;  // 'r'
   localparam logic [7:0] CH_G_UC = 8'h47;  // 'G'
   localparam logic [7:0] CH_G_LC = 8'h67;  // 'g'
   localparam logic [7:0] CH_B_UC = 8'h42;  // 'B'
   localparam logic [7:0] CH_B_LC = 8'h62;  // 'b'
   localparam logic [7:0] ASC_CR  = 8'h0D;
   localparam logic [7:0] ASC_LF  = 8'h0A;
   localparam logic [7:0] ASC_ACK = 8'h4B;  // 'K'
   localparam logic [7:0] ASC_NAK = 8'h45;  // 'E'

   // Channel select
   typedef enum logic [1:0] {
      CHAN_RED   = 2'd0,
      CHAN_GREEN = 2'd1,
      CHAN_BLUE  = 2'd2
   } chan_t;

   typedef struct packed {
      logic  valid;
      chan_t ch;
   } chan_dec_t;

   // Map a received byte to a channel; valid=0 if it is not a channel letter.
   function automatic chan_dec_t decode_chan(input logic [7:0] b);
      chan_dec_t r;
      r.valid = 1'b1;
      r.ch    = CHAN_RED;
      case (b)
         CH_R_UC, CH_R_LC: r.ch = CHAN_RED;
         CH_G_UC, CH_G_LC: r.ch = CHAN_GREEN;
         CH_B_UC, CH_B_LC: r.ch = CHAN_BLUE;
         default:          r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_led_cmd_hex_ascii_decode.sv
// -----------------------------------------------------------------------------
// hex_ascii_decode
// Combinational ASCII hex digit decoder ('0'-'9', 'A'-'F', 'a'-'f').
// Ports:
//   ascii_i   [7:0]  input byte
//   nibble_o  [3:0]  decoded value (0 when not a hex digit)
//   valid_o          1 when ascii_i is a hex digit
// -----------------------------------------------------------------------------
module hex_ascii_decode (
   input  logic [7:0] ascii_i,
   output logic [3:0] nibble_o,
   output logic       valid_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      nibble_o = 4'h0;
      valid_o  = 1'b0;
      if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
         nibble_o = ascii_i[3:0];
         valid_o  = 1'b1;
      end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                   (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
         // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
         nibble_o = ascii_i[3:0] + 4'd9;
         valid_o  = 1'b1;
      end
   end

endmodule

// File: rtl/uart_led_cmd.sv
// -----------------------------------------------------------------------------
// uart_led_cmd
// ASCII command parser between the UART receiver, the UART transmitter and the
// three PWM channels. Accepts "<R|G|B><hex hi><hex lo><CR>" (letters in either
// case), updates the addressed 8-bit duty step and queues a one-byte response,
// 'K' on success or 'E' on a protocol error, via the transmitter's start/busy
// handshake.
//
// Optional feature (compile-time macro UART_LED_CMD_TIMEOUT_EN):
//   abandons a partial command after TIMEOUT_CYCLES cycles without a byte
//   (err_o pulse, no response). Without the macro a partial command waits
//   forever.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   rx_data_i  [7:0]    received byte, valid while rx_valid_i=1
//   rx_valid_i          one-cycle pulse per received byte
//   tx_busy_i           transmitter busy
//   tx_data_o  [7:0]    response byte, stable from start pulse to next response
//   tx_start_o          one-cycle transmit request
//   red_step_o, green_step_o, blue_step_o [7:0]  duty steps
//   err_o               one-cycle pulse on protocol error or dropped byte
// -----------------------------------------------------------------------------
module uart_led_cmd
   import uart_led_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 25000000,
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   input  logic       tx_busy_i,
   output logic [7:0] tx_data_o,
   output logic       tx_start_o,
   output logic [7:0] red_step_o,
   output logic [7:0] green_step_o,
   output logic [7:0] blue_step_o,
   output logic       err_o
);

   localparam int unsigned HOLD_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

   state_t              state_q,   state_d;
   chan_t               chan_q,    chan_d;
   logic [3:0]          hi_q,      hi_d;
   logic [3:0]          lo_q,      lo_d;
   logic [HOLD_W-1:0]   holdoff_q, holdoff_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_start_q, tx_start_d;
   logic                err_q,     err_d;
   logic [7:0]          red_q,     red_d;
   logic [7:0]          green_q,   green_d;
   logic [7:0]          blue_q,    blue_d;

   logic [3:0]          hex_nib;
   logic                hex_ok;
   chan_dec_t           chan_dec;
   logic                proto_err;
   logic                in_cmd;
   logic                timeout_hit;

   hex_ascii_decode u_hex (
      .ascii_i  (rx_data_i),
      .nibble_o (hex_nib),
      .valid_o  (hex_ok)
   );

   assign chan_dec = decode_chan(rx_data_i);
   assign in_cmd   = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_TERM);

`ifdef UART_LED_CMD_TIMEOUT_EN
   logic [31:0] to_cnt_q;

   // Counts idle cycles inside a partial command; any byte restarts it.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         to_cnt_q <= '0;
      end else if (rx_valid_i || !in_cmd || timeout_hit) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 32'd1;
      end
   end

   assign timeout_hit = in_cmd && !rx_valid_i && (to_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      chan_d     = chan_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      holdoff_d  = holdoff_q;
      tx_data_d  = tx_data_q;
      red_d      = red_q;
      green_d    = green_q;
      blue_d     = blue_q;
      tx_start_d = 1'b0;
      err_d      = 1'b0;
      proto_err  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid_i) begin
               if (chan_dec.valid) begin
                  chan_d  = chan_dec.ch;
                  state_d = ST_HI;
               end else if (rx_data_i != ASC_CR && rx_data_i != ASC_LF) begin
                  proto_err = 1'b1;
               end
            end
         end
         ST_HI: begin
            if (rx_valid_i) begin
               if (hex_ok) begin
                  hi_d    = hex_nib;
                  state_d = ST_LO;
               end else begin
                  proto_err = 1'b1;
               end
            end
         end
         ST_LO: begin
            if (rx_valid_i) begin
               if (hex_ok) begin
                  lo_d    = hex_nib;
                  state_d = ST_TERM;
               end else begin
                  proto_err = 1'b1;
               end
            end
         end
         ST_TERM: begin
            if (rx_valid_i) begin
               if (rx_data_i == ASC_CR) begin
                  case (chan_q)
                     CHAN_RED:   red_d   = {hi_q, lo_q};
                     CHAN_GREEN: green_d = {hi_q, lo_q};
                     default:    blue_d  = {hi_q, lo_q};
                  endcase
                  tx_data_d = ASC_ACK;
                  state_d   = ST_RESP_WAIT;
               end else begin
                  proto_err = 1'b1;
               end
            end
         end
         ST_RESP_WAIT: begin
            // A byte here has nowhere to go: flag it and drop it.
            err_d = rx_valid_i;
            if (!tx_busy_i && holdoff_q == '0) begin
               tx_start_d = 1'b1;
               holdoff_d  = HOLD_W'(HOLDOFF_CYCLES);
               state_d    = ST_RESP_HOLD;
            end
         end
         ST_RESP_HOLD: begin
            // tx_busy_i is not looked at here: it may lag the start pulse.
            err_d = rx_valid_i;
            if (holdoff_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               holdoff_d = holdoff_q - HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (proto_err) begin
         err_d     = 1'b1;
         tx_data_d = ASC_NAK;
         state_d   = ST_RESP_WAIT;
      end

      if (timeout_hit) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         chan_q     <= CHAN_RED;
         hi_q       <= 4'h0;
         lo_q       <= 4'h0;
         holdoff_q  <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         red_q      <= 8'h00;
         green_q    <= 8'h00;
         blue_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         chan_q     <= chan_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         holdoff_q  <= holdoff_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         err_q      <= err_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
      end
   end

   assign tx_data_o    = tx_data_q;
   assign tx_start_o   = tx_start_q;
   assign err_o        = err_q;
   assign red_step_o   = red_q;
   assign green_step_o = green_q;
   assign blue_step_o  = blue_q;

endmodule

// File: tb/tb_uart_led_cmd.sv
// -----------------------------------------------------------------------------
// tb_uart_led_cmd
// Directed self-checking bench for uart_led_cmd. Bytes are driven one cycle
// wide just after a rising edge; outputs are sampled on falling edges.
// Define UART_LED_CMD_TIMEOUT_EN for both RTL and bench to also exercise the
// command timeout (TIMEOUT_CYCLES=100).
// -----------------------------------------------------------------------------
module tb_uart_led_cmd;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       tx_busy = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [7:0] red, green, blue;
   logic       err;

   int vectors     = 0;
   int miscompares = 0;

   // Pulse monitors
   int         start_cnt = 0;
   int         err_cnt   = 0;
   logic [7:0] last_tx   = 8'h00;

   int s0, e0;

   always #5 CLK = ~CLK;

   uart_led_cmd #(
      .TIMEOUT_CYCLES (100),
      .HOLDOFF_CYCLES (2)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .tx_busy_i    (tx_busy),
      .tx_data_o    (tx_data),
      .tx_start_o   (tx_start),
      .red_step_o   (red),
      .green_step_o (green),
      .blue_step_o  (blue),
      .err_o        (err)
   );

   always @(negedge CLK) begin
      if (tx_start) begin
         start_cnt = start_cnt + 1;
         last_tx   = tx_data;
      end
      if (err) err_cnt = err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK);
      #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_red",   red,      32'h00);
      check("rst_green", green,    32'h00);
      check("rst_blue",  blue,     32'h00);
      check("rst_txd",   tx_data,  32'h00);
      check("rst_start", tx_start, 32'h0);
      check("rst_err",   err,      32'h0);
      RST_N = 1'b1;
      tick(2);

      // CR / LF in IDLE are ignored
      s0 = start_cnt; e0 = err_cnt;
      send_byte(8'h0D);
      send_byte(8'h0A);
      tick(6);
      check("crlf_err",   err_cnt - e0,   0);
      check("crlf_start", start_cnt - s0, 0);

      // 'R','F','F',CR with tx idle: 2-cycle response latency
      s0 = start_cnt;
      send_byte("R"); send_byte("F"); send_byte("F"); send_byte(8'h0D);
      @(negedge CLK);
      check("t1_lat_c1", tx_start, 32'h0);
      check("t1_red",    red,      32'hFF);
      @(negedge CLK);
      check("t1_lat_c2", tx_start, 32'h1);
      check("t1_txd",    tx_data,  32'h4B);
      tick(8);
      check("t1_nstart", start_cnt - s0, 1);
      check("t1_green",  green, 32'h00);
      check("t1_blue",   blue,  32'h00);

      // 'g','8','0',CR with busy transmitter
      s0 = start_cnt;
      send_byte("g"); send_byte("8"); send_byte("0");
      tx_busy = 1'b1;
      send_byte(8'h0D);
      tick(5);
      check("t2g_held",  start_cnt - s0, 0);
      check("t2_green",  green, 32'h80);
      tx_busy = 1'b0;
      tick(6);
      check("t2g_start", start_cnt - s0, 1);
      check("t2g_txd",   last_tx, 32'h4B);

      // 'b','0','a',CR with busy transmitter
      s0 = start_cnt;
      send_byte("b"); send_byte("0"); send_byte("a");
      tx_busy = 1'b1;
      send_byte(8'h0D);
      tick(5);
      check("t2b_held",  start_cnt - s0, 0);
      tx_busy = 1'b0;
      tick(6);
      check("t2b_start", start_cnt - s0, 1);
      check("t2b_txd",   last_tx, 32'h4B);
      check("t2_blue",   blue,  32'h0A);
      check("t2_green2", green, 32'h80);

      // 'B','1','Z' -> error on 'Z'
      send_byte("B"); send_byte("1");
      s0 = start_cnt; e0 = err_cnt;
      send_byte("Z");
      @(negedge CLK);
      check("t3_err",    err,  32'h1);
      check("t3_blue",   blue, 32'h0A);
      @(negedge CLK);
      check("t3_start",  tx_start, 32'h1);
      check("t3_txd",    tx_data,  32'h45);
      tick(8);
      check("t3_nstart", start_cnt - s0, 1);
      check("t3_nerr",   err_cnt - e0,   1);
      send_byte("R"); send_byte("1"); send_byte("2"); send_byte(8'h0D);
      tick(8);
      check("t3_red",    red, 32'h12);

      // Unknown command letter in IDLE
      s0 = start_cnt; e0 = err_cnt;
      send_byte("X");
      tick(8);
      check("bad_cmd_err", err_cnt - e0,   1);
      check("bad_cmd_rsp", start_cnt - s0, 1);
      check("bad_cmd_txd", last_tx, 32'h45);

      // Long busy period with a byte arriving while the response waits
      tx_busy = 1'b1;
      send_byte("R"); send_byte("3"); send_byte("4"); send_byte(8'h0D);
      s0 = start_cnt; e0 = err_cnt;
      tick(10);
      send_byte("X");
      tick(985);
      check("t4_held",  start_cnt - s0, 0);
      check("t4_drop",  err_cnt - e0,   1);
      tx_busy = 1'b0;
      @(negedge CLK);
      check("t4_c0",    tx_start, 32'h0);
      @(negedge CLK);
      check("t4_c1",    tx_start, 32'h1);
      check("t4_txd",   tx_data,  32'h4B);
      tick(8);
      check("t4_nstart", start_cnt - s0, 1);
      check("t4_red",    red, 32'h34);

      // Reset in the middle of a command
      send_byte("G"); send_byte("7");
      RST_N = 1'b0;
      tick(2);
      check("t5_red",   red,     32'h00);
      check("t5_green", green,   32'h00);
      check("t5_blue",  blue,    32'h00);
      check("t5_txd",   tx_data, 32'h00);
      RST_N = 1'b1;
      s0 = start_cnt;
      tick(10);
      check("t5_nostart", start_cnt - s0, 0);
      send_byte("G"); send_byte("7"); send_byte("7"); send_byte(8'h0D);
      tick(8);
      check("t5_green2", green, 32'h77);
      check("t5_rsp",    start_cnt - s0, 1);

`ifdef UART_LED_CMD_TIMEOUT_EN
      // Partial command abandoned after 100 idle cycles
      send_byte("R"); send_byte("5");
      s0 = start_cnt; e0 = err_cnt;
      tick(105);
      check("to_err",    err_cnt - e0,   1);
      check("to_nostart", start_cnt - s0, 0);
      check("to_red",    red, 32'h00);
      send_byte("3"); send_byte(8'h0D);
      tick(10);
      check("to_rsp",    start_cnt - s0, 1);
      check("to_txd",    last_tx, 32'h45);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
